lzrw1_stream_decompressor: RTL and testbench

Parametrised successor to the LZRW1 decompressor_top. It accepts one compressed item per handshake: a literal, or an offset/length copy from a circular history buffer. It emits one decompressed byte per cycle under ready/valid backpressure, and flags malformed copies. It sits between the compressed-word source (file/DMA feeder) and the byte sink.

---
 rtl/lzrw1_stream_decompressor.sv | 124 ++++++++++++
 tb/tb_lzrw1_stream_decompressor.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzrw1_stream_decompressor.sv
// LZRW1 stream decompressor: accepts literal or offset/length copy items and
// emits one byte per cycle from a circular history buffer under ready/valid flow control.
module lzrw1_stream_decompressor #(
   parameter int unsigned HISTORY_SIZE = 4096,
   parameter int unsigned OFFSET_WIDTH = 12,
   parameter int unsigned MIN_MATCH    = 3
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [15:0] data_in,
   input  logic        control_word_in,
   input  logic        data_in_valid,
   output logic        data_in_ready,
   output logic [7:0]  decompressed_byte,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        decompressor_busy,
   output logic        error
);

   localparam int unsigned LEN_WIDTH = 16 - OFFSET_WIDTH;
   localparam int unsigned AW        = $clog2(HISTORY_SIZE);
   localparam int unsigned FW        = AW + 1;
   localparam int unsigned CNT_W     = $clog2((1 << LEN_WIDTH) + MIN_MATCH) + 1;

   typedef enum logic [1:0] {IDLE, COPY, ERR} state_t;

   state_t            state;
   logic [AW-1:0]     wp;
   logic [AW-1:0]     rd;
   logic [FW-1:0]     fill;
   logic [CNT_W-1:0]  remaining;
   logic [7:0]        last_byte;
   logic [7:0]        mem [HISTORY_SIZE];

   logic [OFFSET_WIDTH-1:0] offset;
   logic [CNT_W-1:0]        length;
   logic [AW-1:0]           copy_src;
   logic [AW-1:0]           rd_addr;
   logic [7:0]              rd_byte;
   logic                    legal;
   logic                    accept;
   logic                    consume;
   logic                    copy_more;
   logic                    copy_done;
   logic                    wr_en;
   logic [7:0]              wr_byte;

   assign offset   = data_in[15:LEN_WIDTH];
   assign length   = CNT_W'(data_in[LEN_WIDTH-1:0]) + CNT_W'(MIN_MATCH);
   assign copy_src = wp - AW'(offset);
   assign legal    = (offset != '0) && (FW'(offset) <= fill);

   assign consume   = out_valid && out_ready;
   assign copy_more = (state == COPY) && consume && (remaining != CNT_W'(1));
   assign copy_done = (state == COPY) && consume && (remaining == CNT_W'(1));

   // Ready rises in the same cycle the last copy byte is consumed, so items chain without a bubble
   assign data_in_ready = ((state == IDLE) && (!out_valid || out_ready)) || copy_done;
   assign accept        = data_in_valid && data_in_ready;

   assign decompressor_busy = (state != IDLE);

   // Newest byte comes from a register so overlapping copies never depend on RAM write timing
   assign rd_addr = accept ? copy_src : rd;
   assign rd_byte = (rd_addr == wp - AW'(1)) ? last_byte : mem[rd_addr];

   assign wr_en   = (accept && (!control_word_in || legal)) || copy_more;
   assign wr_byte = (accept && !control_word_in) ? data_in[7:0] : rd_byte;

   // History RAM; contents are not reset
   always_ff @(posedge clock) begin
      if (wr_en) mem[wp] <= wr_byte;
   end

   // Control FSM with registered byte output and history pointers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state             <= IDLE;
         wp                <= '0;
         rd                <= '0;
         fill              <= '0;
         remaining         <= '0;
         last_byte         <= '0;
         decompressed_byte <= '0;
         out_valid         <= 1'b0;
         error             <= 1'b0;
      end else begin
         if (accept) begin
            if (!control_word_in) begin
               decompressed_byte <= data_in[7:0];
               out_valid         <= 1'b1;
               state             <= IDLE;
            end else if (legal) begin
               decompressed_byte <= rd_byte;
               out_valid         <= 1'b1;
               rd                <= copy_src + AW'(1);
               remaining         <= length;
               state             <= COPY;
            end else begin
               out_valid <= 1'b0;
               error     <= 1'b1;
               state     <= ERR;
            end
         end else if (copy_more) begin
            decompressed_byte <= rd_byte;
            rd                <= rd + AW'(1);
            remaining         <= remaining - CNT_W'(1);
         end else if (copy_done) begin
            out_valid <= 1'b0;
            state     <= IDLE;
         end else if (consume) begin
            out_valid <= 1'b0;
         end

         if (wr_en) begin
            wp        <= wp + AW'(1);
            last_byte <= wr_byte;
            if (fill != FW'(HISTORY_SIZE)) fill <= fill + FW'(1);
         end
      end
   end

endmodule

// File: tb/tb_lzrw1_stream_decompressor.sv
// Bench for lzrw1_stream_decompressor: directed and random items on a default
// instance and a 16-byte-history instance, compared against a queue-based reference model.
module tb_lzrw1_stream_decompressor;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ctrl;
   logic [15:0] in_data;
   logic        out_ready;
   logic        sel;

   logic        a_in_valid, a_ready, a_valid, a_busy, a_err;
   logic [7:0]  a_byte;
   logic        b_in_valid, b_ready, b_valid, b_busy, b_err;
   logic [7:0]  b_byte;

   logic        o_ready, o_valid, o_busy, o_err;
   logic [7:0]  o_byte;

   assign a_in_valid = in_valid && !sel;
   assign b_in_valid = in_valid && sel;
   assign o_ready = sel ? b_ready : a_ready;
   assign o_valid = sel ? b_valid : a_valid;
   assign o_busy  = sel ? b_busy  : a_busy;
   assign o_err   = sel ? b_err   : a_err;
   assign o_byte  = sel ? b_byte  : a_byte;

   lzrw1_stream_decompressor dut_a (
      .clock(clk), .reset(rst), .data_in(in_data), .control_word_in(in_ctrl),
      .data_in_valid(a_in_valid), .data_in_ready(a_ready), .decompressed_byte(a_byte),
      .out_valid(a_valid), .out_ready(out_ready), .decompressor_busy(a_busy), .error(a_err)
   );

   lzrw1_stream_decompressor #(.HISTORY_SIZE(16), .OFFSET_WIDTH(4), .MIN_MATCH(3)) dut_b (
      .clock(clk), .reset(rst), .data_in(in_data), .control_word_in(in_ctrl),
      .data_in_valid(b_in_valid), .data_in_ready(b_ready), .decompressed_byte(b_byte),
      .out_valid(b_valid), .out_ready(out_ready), .decompressor_busy(b_busy), .error(b_err)
   );

   int         n_chk;
   int         n_pass;
   int         got_bytes;
   int         hcap;
   int         ow;
   int         or_mode;
   int         pidx;
   bit         exp_err;
   logic [7:0] hist[$];
   logic [7:0] exp_q[$];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Reference model: whole decompressed stream kept as a growing byte queue
   function automatic bit model_item(input bit ctrl, input logic [15:0] d);
      int off, len, avail;
      logic [7:0] b;
      if (!ctrl) begin
         hist.push_back(d[7:0]);
         exp_q.push_back(d[7:0]);
         return 1'b1;
      end
      off   = int'(d) >> (16 - ow);
      len   = (int'(d) & ((1 << (16 - ow)) - 1)) + 3;
      avail = (hist.size() < hcap) ? hist.size() : hcap;
      if (off == 0 || off > avail) return 1'b0;
      for (int i = 0; i < len; i++) begin
         b = hist[hist.size() - off];
         hist.push_back(b);
         exp_q.push_back(b);
      end
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      #1;
      case (or_mode)
         1: out_ready = 1'($urandom);
         2: begin
            out_ready = (pidx % 4 == 0) || (pidx % 4 == 3);
            pidx++;
         end
         default: out_ready = 1'b1;
      endcase
   end

   always @(negedge clk) begin
      if (!rst && o_valid && out_ready) begin
         got_bytes++;
         if (exp_q.size() == 0) chk("byte_without_expected", 32'(exp_q.size()), 32'd1);
         else chk("out_byte", 32'(o_byte), 32'(exp_q.pop_front()));
      end
   end

   task automatic send(input bit ctrl, input logic [15:0] d);
      int n;
      bit ok;
      n = 0;
      ok = 1'b0;
      in_ctrl = ctrl;
      in_data = d;
      in_valid = 1'b1;
      while (!ok && n < 300) begin
         @(negedge clk);
         if (o_ready) ok = 1'b1;
         else n++;
      end
      if (!ok) chk("send_timeout", 32'(o_ready), 32'd1);
      @(posedge clk);
      if (ok) exp_err = exp_err | !model_item(ctrl, d);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      in_ctrl  = 1'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (n < 3000 && !(exp_q.size() == 0 && !o_valid)) begin
         @(negedge clk);
         n++;
      end
      chk("drained", 32'(exp_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      exp_q.delete();
      hist.delete();
      exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int off, lenf, avail, lim;
      n_chk = 0; n_pass = 0; got_bytes = 0; pidx = 0; or_mode = 0;
      rst = 1'b1; in_valid = 1'b0; in_ctrl = 1'b0; in_data = '0; out_ready = 1'b1;
      sel = 1'b0; hcap = 4096; ow = 12; exp_err = 1'b0;
      #2;
      do_reset();

      chk("reset_out_valid", 32'(o_valid), 32'd0);
      chk("reset_byte", 32'(o_byte), 32'd0);
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_error", 32'(o_err), 32'd0);

      // Literals with one-cycle latency
      send(1'b0, 16'h0041);
      @(negedge clk);
      chk("lit_latency_valid", 32'(o_valid), 32'd1);
      chk("lit_latency_byte", 32'(o_byte), 32'h41);
      @(posedge clk); #1;
      send(1'b0, 16'h0042);
      send(1'b0, 16'h0043);

      // Copy offset 3 length 3: ready low two cycles then high on last byte
      send(1'b1, 16'h0030);
      @(negedge clk);
      chk("copy_ready_c1", 32'(o_ready), 32'd0);
      chk("copy_busy_c1", 32'(o_busy), 32'd1);
      @(negedge clk);
      chk("copy_ready_c2", 32'(o_ready), 32'd0);
      @(negedge clk);
      chk("copy_ready_c3", 32'(o_ready), 32'd1);
      @(posedge clk); #1;
      drain();
      chk("error_clean", 32'(o_err), 32'(exp_err));

      // Overlapping copy offset 1 length 5
      send(1'b0, 16'h0041);
      send(1'b1, 16'h0012);
      drain();

      // Stalled overlapping copy of length 6, busy must hold throughout
      or_mode = 2; pidx = 0;
      send(1'b1, 16'h0023);
      for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
         @(negedge clk);
         if (exp_q.size() != 0) chk("busy_during_stall", 32'(o_busy), 32'd1);
      end
      drain();

      // Random literals and legal copies with random backpressure
      or_mode = 1;
      for (int i = 0; i < 150; i++) begin
         if (int'($urandom_range(0, 9)) < 6 || hist.size() == 0) begin
            send(1'b0, 16'($urandom));
         end else begin
            avail = (hist.size() < 4095) ? hist.size() : 4095;
            lim   = (avail < 8) ? avail : 8;
            off   = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, lim))
                                                 : int'($urandom_range(1, avail));
            lenf  = int'($urandom_range(0, 15));
            send(1'b1, 16'((off << (16 - ow)) | lenf));
         end
      end
      drain();
      chk("random_error", 32'(o_err), 32'(exp_err));
      or_mode = 0;

      // Copy reaching beyond fill
      do_reset();
      send(1'b0, 16'h0078);
      send(1'b0, 16'h0079);
      drain();
      send(1'b1, 16'h0050);
      @(negedge clk);
      chk("ovf_error", 32'(o_err), 32'(exp_err));
      chk("ovf_ready", 32'(o_ready), 32'd0);
      chk("ovf_valid", 32'(o_valid), 32'd0);
      chk("ovf_busy", 32'(o_busy), 32'd1);
      in_ctrl = 1'b0; in_data = 16'h0055; in_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("err_ready_held", 32'(o_ready), 32'd0);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;

      // Zero offset
      do_reset();
      chk("err_cleared", 32'(o_err), 32'd0);
      send(1'b1, 16'h0005);
      @(negedge clk);
      chk("zero_off_error", 32'(o_err), 32'(exp_err));
      chk("zero_off_ready", 32'(o_ready), 32'd0);
      @(posedge clk); #1;

      // Small history: copy across wrap
      sel = 1'b1; hcap = 16; ow = 4;
      do_reset();
      for (int i = 0; i < 20; i++) send(1'b0, 16'(i));
      send(1'b1, 16'hF000);
      drain();
      chk("wrap_error", 32'(o_err), 32'(exp_err));

      // Reset in the middle of a long copy
      send(1'b1, 16'hF00F);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midreset_valid", 32'(o_valid), 32'd0);
      chk("midreset_busy", 32'(o_busy), 32'd0);
      chk("midreset_byte", 32'(o_byte), 32'd0);
      chk("midreset_error", 32'(o_err), 32'd0);
      exp_q.delete(); hist.delete(); exp_err = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      got_bytes = 0;
      send(1'b0, 16'h005A);
      drain();
      chk("after_reset_count", 32'(got_bytes), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
